serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: addend A.
REQ-007 The block SHALL have port b, input, WIDTH bits: addend B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result, a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out of bit WIDTH-1.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The block SHALL instantiate exactly one 1-bit full adder (s = x^y^c; co = x&y | c&(x^y)) and SHALL time-share it across all bit positions, LSB first.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE; encoding is free.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be driven from registered state.
REQ-017 In IDLE, on in_valid=1, the block SHALL on that edge load a and b into shift registers, load cin into the carry flop, clear the bit counter to 0, and go to RUN.
REQ-018 In RUN, each cycle the block SHALL add a_sh[0], b_sh[0] and carry; right-shift a_sh and b_sh; shift the adder sum into sum_sh at bit WIDTH-1; register the adder carry-out; and increment the counter.
REQ-019 In RUN with counter = WIDTH-1, the block SHALL do the REQ-018 step on that edge and go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge; for WIDTH=8, 8 edges.
REQ-021 In DONE, sum SHALL equal sum_sh and cout SHALL equal the carry flop; both SHALL stay stable until the handshake completes.
REQ-022 In DONE, on out_ready=1, the block SHALL go to IDLE on that edge; with out_ready=0, the block SHALL hold DONE indefinitely.
REQ-023 in_valid SHALL be ignored in RUN and DONE; operand inputs SHALL be sampled only on the accepting edge and SHALL not be required to stay stable afterwards.
REQ-024 The block SHALL return to IDLE, never straight to RUN, when out_ready=1 and in_valid=1 occur together in DONE; minimum spacing is WIDTH+2 cycles per operation.
REQ-025 The counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap during RUN.
REQ-026 Outside DONE, sum and cout SHALL read 0; internal shift contents SHALL not be visible on the outputs.

Reset
REQ-027 On a rising clk edge with rst_n=0, the block SHALL set state to IDLE and clear the counter, carry, a_sh, b_sh and sum_sh to 0.
REQ-028 After reset, in_ready SHALL be 1, out_valid 0, busy 0, sum 0 and cout 0 from the first edge with rst_n=0.
REQ-029 A reset asserted during RUN or DONE SHALL abort the operation; no result SHALL be presented for it.
REQ-030 The first in_valid honoured after reset SHALL be on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-031 The bench SHALL apply a=0x0F, b=0x01, cin=0 and SHALL check out_valid rising 8 edges after acceptance, with sum=0x10 and cout=0.
REQ-032 The bench SHALL apply a=0xFF, b=0x01, cin=0 and SHALL check sum=0x00 and cout=1; then a=0xFF, b=0xFF, cin=1 and SHALL check sum=0xFF and cout=1.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE and SHALL check that sum, cout and out_valid stay stable, in_ready=0 and busy=1; on out_ready=1, the block returns to IDLE next edge.
REQ-034 The bench SHALL pulse in_valid with a=0xAA in RUN after accepting a=0x55, b=0x00, and SHALL check that the result is 0x55 and the 0xAA pulse is ignored.
REQ-035 The bench SHALL drive rst_n=0 at bit 4 of RUN and SHALL check that the next edge gives in_ready=1, busy=0, out_valid=0 and sum=0; the next accepted operation must give the correct result.
REQ-036 The bench SHALL run 1000 random operands with random out_ready back-pressure and SHALL compare each result against a reference model of a+b+cin.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder walks the operands LSB first,
// taking WIDTH cycles per addition. Operands and result use valid/ready handshakes.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ c;
    assign co = (x & y) | (c & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; in_ready is high only in IDLE, out_valid only in DONE, and the
    // result stays frozen while out_valid waits for out_ready.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    // The last bit leaves the counter parked so it never wraps.
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Results are gated so the shift registers never leak onto the outputs.
    assign sum  = out_valid ? sum_sh : '0;
    assign cout = out_valid & carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against an arithmetic
// model of a+b+cin, including latency, back-pressure and reset abort.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_vec;
    int n_err;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum_cout"}, {23'd0, cout, sum}, 32'd0);
    endtask

    // Called at a falling edge with the DUT idle. Applies one operation and
    // follows it to the result handshake.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int hold, input int pulse_at,
                          input bit overlap, input bit rand_ready);
        logic [W:0]   exp_full;
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           lat;
        exp_full  = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        a         = ta;
        b         = tb;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        check("accept_in_ready", 32'(in_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            check("run_outputs_zero", {23'd0, cout, sum}, 32'd0);
            if (lat == pulse_at) begin
                in_valid = 1'b1;
                a        = 8'hAA;
            end else begin
                in_valid = 1'b0;
            end
            if (rand_ready) out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(lat), 32'(W));
        check("out_valid", 32'(out_valid), 32'd1);
        check("sum", 32'(sum), 32'(exp_full[W-1:0]));
        check("cout", 32'(cout), 32'(exp_full[W]));
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'(held_sum));
            check("hold_cout", 32'(cout), 32'(held_cout));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        if (overlap) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle("release");
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        // Operand applied with reset release must be taken on the first edge.
        rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 0, -1, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, -1, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, -1, 1'b0, 1'b0);
        run_op(8'h3C, 8'h5A, 1'b1, 5, -1, 1'b0, 1'b0);
        run_op(8'h55, 8'h00, 1'b0, 1, 3, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 2, -1, 1'b1, 1'b0);
        @(negedge clk);
        check_idle("after_overlap");

        // Abort mid-operation with the counter at bit 4.
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("abort");
        @(negedge clk);
        check_idle("abort_held");
        rst_n = 1'b1;
        run_op(8'h9A, 8'h27, 1'b1, 0, -1, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 4), -1,
                   1'($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
